// File: rtl/vpu_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vpu_fp_add_arbiter
// Brief    : Round-robin share of one pipelined FP add/sub unit between
//            NUM_REQ requesters, with in-order tag return steering.
// Revision : 1.0
// ============================================================================
module vpu_fp_add_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int OPERAND_WIDTH   = 32,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0]     req_a_i,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0]     req_b_i,
    input  logic [NUM_REQ-1:0]                   req_sub_i,
    output logic                                 fpu_tvalid_o,
    output logic [OPERAND_WIDTH-1:0]             fpu_a_o,
    output logic [OPERAND_WIDTH-1:0]             fpu_b_o,
    output logic [7:0]                           fpu_op_o,
    input  logic                                 fpu_result_tvalid_i,
    input  logic [OPERAND_WIDTH-1:0]             fpu_result_tdata_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    output logic [OPERAND_WIDTH-1:0]             rsp_data_o,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
    output logic                                 err_unexpected_o
);

    localparam int c_TAG_W = $clog2(NUM_REQ);
    localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_TAG_W-1:0]       r_ptr;
    logic [c_CNT_W-1:0]       r_count;
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_TAG_W-1:0]       r_tag_mem [MAX_OUTSTANDING];

    logic                     r_fpu_tvalid;
    logic [OPERAND_WIDTH-1:0] r_fpu_a;
    logic [OPERAND_WIDTH-1:0] r_fpu_b;
    logic [7:0]               r_fpu_op;
    logic [NUM_REQ-1:0]       r_rsp_valid;
    logic [OPERAND_WIDTH-1:0] r_rsp_data;
    logic                     r_err;

    logic [c_TAG_W:0]         w_idx;
    logic [c_TAG_W-1:0]       w_grant_idx;
    logic                     w_found;
    logic                     w_credit_ok;
    logic                     w_fire;
    logic                     w_pop;
    logic                     w_unexpected;
    logic [c_TAG_W-1:0]       w_ptr_next;
    logic [OPERAND_WIDTH-1:0] w_a;
    logic [OPERAND_WIDTH-1:0] w_b;
    logic                     w_sub;

    // Scan offsets from the highest down so the nearest valid requester to
    // r_ptr is the last (and therefore winning) assignment.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (c_TAG_W + 1)'(k);
            if (w_idx >= (c_TAG_W + 1)'(NUM_REQ)) begin
                w_idx = w_idx - (c_TAG_W + 1)'(NUM_REQ);
            end
            if (req_valid_i[w_idx[c_TAG_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx[c_TAG_W-1:0];
            end
        end
    end

    assign w_credit_ok  = (r_count < c_CNT_W'(MAX_OUTSTANDING));
    assign w_fire       = w_found & w_credit_ok & rst_n;
    assign req_ready_o  = w_fire ? (NUM_REQ'(1) << w_grant_idx) : '0;

    assign w_ptr_next   = (w_grant_idx == c_TAG_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_a          = req_a_i[w_grant_idx*OPERAND_WIDTH +: OPERAND_WIDTH];
    assign w_b          = req_b_i[w_grant_idx*OPERAND_WIDTH +: OPERAND_WIDTH];
    assign w_sub        = req_sub_i[w_grant_idx];

    // Occupancy of the tag FIFO is exactly the outstanding count, so the
    // emptiness test uses the pre-push count: a same-cycle push cannot be popped.
    assign w_pop        = fpu_result_tvalid_i & (r_count != '0);
    assign w_unexpected = fpu_result_tvalid_i & (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fpu_tvalid <= 1'b0;
            r_fpu_a      <= '0;
            r_fpu_b      <= '0;
            r_fpu_op     <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_fpu_tvalid <= w_fire;
            if (w_fire) begin
                r_ptr    <= w_ptr_next;
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_fpu_a  <= w_a;
                r_fpu_b  <= w_b;
                r_fpu_op <= {7'd0, w_sub};
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_rsp_valid <= NUM_REQ'(1) << r_tag_mem[r_rd_ptr];
                r_rsp_data  <= fpu_result_tdata_i;
            end else begin
                r_rsp_valid <= '0;
            end
            case ({w_fire, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_unexpected) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_tag_mem[r_wr_ptr] <= w_grant_idx;
        end
    end

    assign fpu_tvalid_o     = r_fpu_tvalid;
    assign fpu_a_o          = r_fpu_a;
    assign fpu_b_o          = r_fpu_b;
    assign fpu_op_o         = r_fpu_op;
    assign rsp_valid_o      = r_rsp_valid;
    assign rsp_data_o       = r_rsp_data;
    assign outstanding_o    = r_count;
    assign err_unexpected_o = r_err;

endmodule
`default_nettype wire
